// File: rtl/game_controller_if.sv
// Signal bundle between the game sequencer and its environment (buttons,
// frame timing in; positions, scores and match state out to the video encoder).
interface game_controller_if;
  logic        frame_tick;
  logic        serve;
  logic        l_up;
  logic        l_down;
  logic        r_up;
  logic        r_down;
  logic        bat_size;
  logic [1:0]  mode;
  logic [10:0] ball_x;
  logic [10:0] ball_y;
  logic [10:0] bat_l_y;
  logic [10:0] bat_r_y;
  logic [5:0]  score_l;
  logic [5:0]  score_r;
  logic [1:0]  game_state;
  logic        update_done;

  modport master (
    output frame_tick, serve, l_up, l_down, r_up, r_down, bat_size, mode,
    input  ball_x, ball_y, bat_l_y, bat_r_y, score_l, score_r, game_state, update_done
  );

  modport slave (
    input  frame_tick, serve, l_up, l_down, r_up, r_down, bat_size, mode,
    output ball_x, ball_y, bat_l_y, bat_r_y, score_l, score_r, game_state, update_done
  );
endinterface

// File: rtl/game_controller.sv
// Per-frame ball-and-paddle sequencer: on each frame_tick it moves the bats,
// then the ball, then resolves points and match state, all registered.
module game_controller #(
  parameter int H_ACTIVE     = 800,
  parameter int V_ACTIVE     = 600,
  parameter int BALL_SIZE    = 8,
  parameter int BAT_W        = 8,
  parameter int BAT_H_SMALL  = 40,
  parameter int BAT_H_LARGE  = 80,
  parameter int BAT_L_X      = 16,
  parameter int BAT_R_X      = 776,
  parameter int BAT_SPEED    = 4,
  parameter int BALL_SPEED   = 2,
  parameter int WIN_SCORE    = 9,
  parameter int PAUSE_FRAMES = 60
) (
  input logic clk,
  input logic rst,
  game_controller_if.slave bus
);

  localparam int PW = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;

  localparam logic [10:0] BX0  = 11'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [10:0] BY0  = 11'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [10:0] BAT0 = 11'((V_ACTIVE - BAT_H_SMALL) / 2);

  localparam logic [11:0] VA    = 12'(V_ACTIVE);
  localparam logic [11:0] BSZ   = 12'(BALL_SIZE);
  localparam logic [11:0] HBSZ  = 12'(BALL_SIZE / 2);
  localparam logic [11:0] BH_S  = 12'(BAT_H_SMALL);
  localparam logic [11:0] BH_L  = 12'(BAT_H_LARGE);
  localparam logic [11:0] BSPD  = 12'(BAT_SPEED);
  localparam logic [11:0] SPD1  = 12'(BALL_SPEED);
  localparam logic [11:0] SPD2  = 12'(2 * BALL_SPEED);
  localparam logic [11:0] LFACE = 12'(BAT_L_X + BAT_W);
  localparam logic [11:0] RFACE = 12'(BAT_R_X);
  localparam logic [11:0] XMAX  = 12'(H_ACTIVE - BALL_SIZE);
  localparam logic [11:0] YMAX  = 12'(V_ACTIVE - BALL_SIZE);

  typedef enum logic [1:0] {S_WAIT, S_BATS, S_BALL, S_RESOLVE} seq_e;
  typedef enum logic [1:0] {G_IDLE = 2'd0, G_PLAY = 2'd1, G_SCORED = 2'd2, G_OVER = 2'd3} game_e;

  seq_e        seq_q, seq_d;
  game_e       game_q, game_d;
  logic [10:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic [10:0] bat_l_q, bat_l_d, bat_r_q, bat_r_d;
  logic [5:0]  score_l_q, score_l_d, score_r_q, score_r_d;
  logic        dx_q, dx_d, dy_q, dy_d;
  logic [PW-1:0] pause_q, pause_d;
  logic        miss_l_q, miss_l_d, miss_r_q, miss_r_d;
  logic        done_q, done_d;

  logic [11:0] bh, bat_lim, spd, bx, by, bl, br, half_bh, by_c, cpu_tgt;
  logic        cpu_up, cpu_dn, r_up_eff, r_dn_eff, ovl, ovr;
  logic [5:0]  sl_n, sr_n;
  logic [PW-1:0] pause_n;

  function automatic logic [11:0] bat_step(logic [11:0] y, logic up, logic dn,
                                           logic [11:0] lim);
    logic [11:0] n;
    n = y;
    if (up && !dn)      n = (y < BSPD) ? 12'd0 : y - BSPD;
    else if (dn && !up) n = y + BSPD;
    // clamp even when idle so a bat_size increase pulls the bat back in
    return (n > lim) ? lim : n;
  endfunction

  assign bh      = bus.bat_size ? BH_L : BH_S;
  assign bat_lim = VA - bh;
  assign spd     = bus.mode[0] ? SPD2 : SPD1;
  assign bx      = {1'b0, ball_x_q};
  assign by      = {1'b0, ball_y_q};
  assign bl      = {1'b0, bat_l_q};
  assign br      = {1'b0, bat_r_q};

  // CPU aims the bat centre at the ball centre, saturating the target at 0
  assign half_bh  = bh >> 1;
  assign by_c     = by + HBSZ;
  assign cpu_tgt  = (by_c < half_bh) ? 12'd0 : by_c - half_bh;
  assign cpu_up   = (br > cpu_tgt) && ((br - cpu_tgt) > BSPD);
  assign cpu_dn   = (cpu_tgt > br) && ((cpu_tgt - br) > BSPD);
  assign r_up_eff = bus.mode[1] ? cpu_up : bus.r_up;
  assign r_dn_eff = bus.mode[1] ? cpu_dn : bus.r_down;

  // pre-move ball_y against bats already updated this frame
  assign ovl = ((by + BSZ) > bl) && (by < (bl + bh));
  assign ovr = ((by + BSZ) > br) && (by < (br + bh));

  assign sl_n    = (miss_r_q && score_l_q != 6'h3F) ? score_l_q + 6'd1 : score_l_q;
  assign sr_n    = (miss_l_q && score_r_q != 6'h3F) ? score_r_q + 6'd1 : score_r_q;
  assign pause_n = pause_q + PW'(1);

  always_comb begin
    seq_d     = seq_q;
    game_d    = game_q;
    ball_x_d  = ball_x_q;
    ball_y_d  = ball_y_q;
    bat_l_d   = bat_l_q;
    bat_r_d   = bat_r_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    pause_d   = pause_q;
    miss_l_d  = miss_l_q;
    miss_r_d  = miss_r_q;
    done_d    = 1'b0;

    unique case (seq_q)
      S_WAIT: if (bus.frame_tick) seq_d = S_BATS;

      S_BATS: begin
        bat_l_d = 11'(bat_step(bl, bus.l_up, bus.l_down, bat_lim));
        bat_r_d = 11'(bat_step(br, r_up_eff, r_dn_eff, bat_lim));
        seq_d   = S_BALL;
      end

      S_BALL: begin
        seq_d    = S_RESOLVE;
        miss_l_d = 1'b0;
        miss_r_d = 1'b0;
        if (game_q == G_PLAY) begin
          if (!dy_q) begin
            if (by < spd) begin ball_y_d = '0; dy_d = 1'b1; end
            else ball_y_d = 11'(by - spd);
          end else begin
            if ((by + spd) > YMAX) begin ball_y_d = 11'(YMAX); dy_d = 1'b0; end
            else ball_y_d = 11'(by + spd);
          end

          if (!dx_q) begin
            if (bx >= LFACE && (bx - spd) < LFACE && ovl) begin
              ball_x_d = 11'(LFACE);
              dx_d     = 1'b1;
            end else if (bx < spd) miss_l_d = 1'b1;
            else ball_x_d = 11'(bx - spd);
          end else begin
            if ((bx + BSZ) <= RFACE && (bx + BSZ + spd) > RFACE && ovr) begin
              ball_x_d = 11'(RFACE - BSZ);
              dx_d     = 1'b0;
            end else if ((bx + spd) > XMAX) miss_r_d = 1'b1;
            else ball_x_d = 11'(bx + spd);
          end
        end
      end

      S_RESOLVE: begin
        seq_d    = S_WAIT;
        done_d   = 1'b1;
        miss_l_d = 1'b0;
        miss_r_d = 1'b0;
        if (game_q == G_PLAY && (miss_l_q || miss_r_q)) begin
          score_l_d = sl_n;
          score_r_d = sr_n;
          if (sl_n == 6'(WIN_SCORE) || sr_n == 6'(WIN_SCORE)) begin
            game_d = G_OVER;
          end else begin
            game_d   = G_SCORED;
            pause_d  = '0;
            ball_x_d = BX0;
            ball_y_d = BY0;
            dx_d     = miss_r_q;  // serve toward whoever conceded
            dy_d     = 1'b1;
          end
        end else begin
          unique case (game_q)
            G_IDLE: if (bus.serve) begin
              game_d = G_PLAY;
              dx_d   = 1'b1;
              dy_d   = 1'b1;
            end
            G_SCORED: begin
              pause_d = pause_n;
              if (pause_n == PW'(PAUSE_FRAMES - 1)) game_d = G_PLAY;
            end
            G_OVER: if (bus.serve) begin
              score_l_d = '0;
              score_r_d = '0;
              ball_x_d  = BX0;
              ball_y_d  = BY0;
              game_d    = G_IDLE;
            end
            default: ;
          endcase
        end
      end

      default: seq_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q     <= S_WAIT;
      game_q    <= G_IDLE;
      ball_x_q  <= BX0;
      ball_y_q  <= BY0;
      bat_l_q   <= BAT0;
      bat_r_q   <= BAT0;
      score_l_q <= '0;
      score_r_q <= '0;
      dx_q      <= 1'b1;
      dy_q      <= 1'b1;
      pause_q   <= '0;
      miss_l_q  <= 1'b0;
      miss_r_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      seq_q     <= seq_d;
      game_q    <= game_d;
      ball_x_q  <= ball_x_d;
      ball_y_q  <= ball_y_d;
      bat_l_q   <= bat_l_d;
      bat_r_q   <= bat_r_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      pause_q   <= pause_d;
      miss_l_q  <= miss_l_d;
      miss_r_q  <= miss_r_d;
      done_q    <= done_d;
    end
  end

  assign bus.ball_x      = ball_x_q;
  assign bus.ball_y      = ball_y_q;
  assign bus.bat_l_y     = bat_l_q;
  assign bus.bat_r_y     = bat_r_q;
  assign bus.score_l     = score_l_q;
  assign bus.score_r     = score_r_q;
  assign bus.game_state  = game_q;
  assign bus.update_done = done_q;

endmodule

// File: doc/game_controller.md
Name: game_controller

Overview:
- Per-frame game sequencer for the ball-and-paddle design.
- Owns ball position and velocity, both bat positions, both scores and the match state machine.
- Drives the position and score inputs of the video encoder, replacing the constant tie-offs used today.
- Advances exactly once per frame, on frame_tick, using a fixed 3-step internal sequence.

Parameters:
- H_ACTIVE, 800, visible width in pixels
- V_ACTIVE, 600, visible height in pixels
- BALL_SIZE, 8, ball edge length
- BAT_W, 8, bat width
- BAT_H_SMALL, 40, bat height when bat_size=0
- BAT_H_LARGE, 80, bat height when bat_size=1
- BAT_L_X, 16, left bat left edge x
- BAT_R_X, 776, right bat left edge x
- BAT_SPEED, 4, bat pixels per frame
- BALL_SPEED, 2, ball pixels per frame per axis
- WIN_SCORE, 9, points needed to win
- PAUSE_FRAMES, 60, frames held after a point

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse, once per frame, at vertical blank start
- serve  in  1  start or resume play (level, sampled in the RESOLVE step)
- l_up, l_down, r_up, r_down  in  1 each  bat controls
- bat_size  in  1  0=small, 1=large bats
- mode  in  2  [0]=double ball speed; [1]=right bat CPU-controlled
- ball_x, ball_y  out  11 each  ball top-left corner
- bat_l_y, bat_r_y  out  11 each  bat top edges
- score_l, score_r  out  6 each  scores
- game_state  out  2  0=IDLE, 1=PLAY, 2=SCORED, 3=OVER
- update_done  out  1  one-cycle pulse when a frame update completes

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high, interface exactly so.
- Reset, or rst asserted at any point including mid-sequence, takes effect at the next edge:
  - ball = (396, 296), bats = 280
  - scores = 0, game_state = IDLE, sequencer = WAIT
  - update_done = 0, dx = 1, dy = 1, pause counter = 0
- Sequencer: WAIT -> BATS -> BALL -> RESOLVE -> WAIT.
  - frame_tick is seen in WAIT at edge k.
  - Bats update at edge k+1, ball at k+2, scores/state at k+3.
  - update_done is high for the cycle after edge k+3.
  - frame_tick outside WAIT is ignored.
- Speed: s = BALL_SPEED << mode[0]. bh = bat_size ? BAT_H_LARGE : BAT_H_SMALL.
- BATS step (every game state):
  - up only: y = max(y - BAT_SPEED, 0).
  - down only: y = min(y + BAT_SPEED, V_ACTIVE - bh).
  - Both or neither pressed: y holds. The min clamp is applied even when not moving, which covers a bat_size increase.
  - mode[1]=1: right-bat inputs are ignored. The bat moves BAT_SPEED toward ball_y + 4 - bh/2 with the same clamps; no move if within BAT_SPEED of target.
- BALL step (PLAY only; other states hold the ball at centre):
  - Y axis:
    - dy=0 and y < s: y = 0, dy = 1.
    - dy=1 and y + s > V_ACTIVE - 8: y = 592, dy = 0.
    - Otherwise y moves by s.
  - Overlap test: ball_y + 8 > bat_y and ball_y < bat_y + bh. It uses the pre-move ball_y and the post-BATS bat_y.
  - Left side, dx=0:
    - If x >= 24 and x - s < 24 and the left bat overlaps: x = 24, dx = 1.
    - Else if x < s: miss_l.
    - Else x -= s.
  - Right side, dx=1:
    - If x + 8 <= 776 and x + 8 + s > 776 and the right bat overlaps: x = 768, dx = 0.
    - Else if x + s > 792: miss_r.
    - Else x += s.
  - All arithmetic is 12-bit unsigned.
- RESOLVE step:
  - miss_l: score_r += 1. miss_r: score_l += 1. Scores saturate at 63.
  - After a point:
    - If either score equals WIN_SCORE: OVER.
    - Else: SCORED, pause counter = 0, ball recentred, dx set toward the side that conceded, dy = 1.
  - SCORED: pause counter increments each frame; at PAUSE_FRAMES-1 the state goes to PLAY.
  - IDLE with serve=1: PLAY, dx = 1, dy = 1.
  - OVER with serve=1: scores cleared, ball recentred, state IDLE.
- All outputs are registered; there is no combinational path from any input to any output.

Test Plan:
- Reset, then 3 frame_ticks with no buttons -> ball (396,296), bats 280, scores 0, IDLE; update_done pulses once per tick, 4 cycles after each tick.
- serve=1, 10 frames, mode=0 -> PLAY; ball_x = 396+20 = 416 (or +18 if serve was sampled in the first frame's RESOLVE step); dy flips at y=592 on a long run.
- Hold l_up for 100 frames -> bat_l_y saturates at 0; then bat_size 0->1 with bat_r_y=560 -> bat_r_y clamps to 520 in the next BATS step.
- Park the right bat at 280 and the ball at y=296 approaching x=766 with s=2 -> ball_x = 768, dx = 0, score unchanged.
- Right bat at 0 with the ball at y=296 -> the ball passes, miss_r, score_l = 1, SCORED; the ball moves again exactly 60 frames later with dx = 1.
- Play to score_l = 9 -> OVER and the ball frozen; serve -> IDLE with scores 0. rst mid-sequence (cycle k+2) -> all reset values at the next edge and no update_done pulse.
